// File: rtl/hazard_scheduler_if.sv
// rtl/hazard_scheduler_if.sv - ID-stage to hazard scheduler signal bundle
//
// Purpose: groups the decode-stage instruction fields, the global hold and
// the scheduler's pipeline-control outputs into one bundle.
// Modports:
//   master - ID stage side: drives hold and id_* fields, observes controls
//   slave  - hazard scheduler side: reads hold and id_*, drives
//            stall / bubble / flush / stall_cnt
interface hazard_scheduler_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              hold;
  logic              id_valid;
  logic [REG_AW-1:0] id_src1;
  logic [REG_AW-1:0] id_src2;
  logic              id_src1_used;
  logic              id_src2_used;
  logic              id_branch;
  logic [REG_AW-1:0] id_dest;
  logic              id_wb_en;
  logic              id_mem_r_en;
  logic              id_br_taken;
  logic              stall;
  logic              bubble;
  logic              flush;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output hold, id_valid, id_src1, id_src2, id_src1_used, id_src2_used,
           id_branch, id_dest, id_wb_en, id_mem_r_en, id_br_taken,
    input  stall, bubble, flush, stall_cnt
  );

  modport slave (
    input  hold, id_valid, id_src1, id_src2, id_src1_used, id_src2_used,
           id_branch, id_dest, id_wb_en, id_mem_r_en, id_br_taken,
    output stall, bubble, flush, stall_cnt
  );
endinterface

// File: rtl/hazard_scheduler.sv
// rtl/hazard_scheduler.sv - five-stage pipeline hazard scheduler (stall / bubble / flush)
//
// Purpose: tracks the destination registers of the instructions in EXE and
// MEM and compares them against the decoding instruction's sources. On a
// RAW hazard it freezes PC and IF/ID (stall) and injects a bubble into
// ID/EX; on a resolved taken branch with no hazard it flushes IF/ID.
// Optional feature macro: FORWARDING_EN (EXE forwarding present, so only
// load-use and branch-operand hazards stall). Undefined = full interlock.
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous reset, active low
//   bus - hazard_scheduler_if.slave: hold, id_* inputs; stall, bubble,
//         flush, stall_cnt outputs
module hazard_scheduler #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_scheduler_if.slave    bus
);

  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic              mem_r;
    logic [REG_AW-1:0] dest;
  } sb_entry_t;

  sb_entry_t        exe_q, exe_d;
  sb_entry_t        mem_q, mem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic exe_hit, mem_hit, hz, stall_w;

  // Register 0 is hard-wired, so it can never be a true dependency.
  function automatic logic src_hit(sb_entry_t e, logic [REG_AW-1:0] s, logic used);
    return used && (s != '0) && e.valid && e.wb_en && (e.dest == s);
  endfunction

  assign exe_hit = src_hit(exe_q, bus.id_src1, bus.id_src1_used) ||
                   src_hit(exe_q, bus.id_src2, bus.id_src2_used);
  assign mem_hit = src_hit(mem_q, bus.id_src1, bus.id_src1_used) ||
                   src_hit(mem_q, bus.id_src2, bus.id_src2_used);

`ifdef FORWARDING_EN
  // Branches compare in ID and see no forwarding, so they wait for any EXE
  // producer and for a load still in MEM; everything else only for load-use.
  assign hz = bus.id_valid &&
              (bus.id_branch ? (exe_hit || (mem_hit && mem_q.mem_r))
                             : (exe_hit && exe_q.mem_r));
`else
  assign hz = bus.id_valid && (exe_hit || mem_hit);
`endif

  // A global hold already freezes every stage, so local controls stay quiet.
  assign stall_w        = hz && !bus.hold;
  assign bus.stall      = stall_w;
  assign bus.bubble     = stall_w;
  assign bus.flush      = bus.id_valid && bus.id_branch && bus.id_br_taken &&
                          !hz && !bus.hold;
  assign bus.stall_cnt  = cnt_q;

  always_comb begin
    exe_d = exe_q;
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (!bus.hold) begin
      mem_d = exe_q;
      if (stall_w || !bus.id_valid) begin
        exe_d = '0;
      end else begin
        // A flushing branch still advances; only the fetched slot dies.
        exe_d = {1'b1, bus.id_wb_en, bus.id_mem_r_en, bus.id_dest};
      end
      if (stall_w && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_q <= '0;
      mem_q <= '0;
      cnt_q <= '0;
    end else begin
      exe_q <= exe_d;
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb/tb_hazard_scheduler.sv - self-checking bench for hazard_scheduler
module tb_hazard_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_scheduler_if #(.REG_AW(5), .CNT_W(16)) bus ();
  hazard_scheduler_if #(.REG_AW(5), .CNT_W(4))  sat_bus ();

  hazard_scheduler #(.REG_AW(5), .CNT_W(16)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  hazard_scheduler #(.REG_AW(5), .CNT_W(4))  u_sat (.clk(clk), .rst(rst), .bus(sat_bus));

  // Narrow-counter twin sees identical stimulus so saturation is reachable quickly.
  assign sat_bus.hold         = bus.hold;
  assign sat_bus.id_valid     = bus.id_valid;
  assign sat_bus.id_src1      = bus.id_src1;
  assign sat_bus.id_src2      = bus.id_src2;
  assign sat_bus.id_src1_used = bus.id_src1_used;
  assign sat_bus.id_src2_used = bus.id_src2_used;
  assign sat_bus.id_branch    = bus.id_branch;
  assign sat_bus.id_dest      = bus.id_dest;
  assign sat_bus.id_wb_en     = bus.id_wb_en;
  assign sat_bus.id_mem_r_en  = bus.id_mem_r_en;
  assign sat_bus.id_br_taken  = bus.id_br_taken;

  typedef struct {
    bit       hold, valid;
    logic [4:0] s1, s2, dest;
    bit       u1, u2, br, tk, wb, mr;
    bit [1:0] e_nf, e_fw;   // {stall, flush} without / with forwarding
  } vec_t;

  typedef struct {
    bit         v, wb, mr;
    logic [4:0] dest;
  } rec_t;

  localparam bit [1:0] N = 2'b00, S = 2'b10, F = 2'b01;

  int   n_cmp = 0;
  int   n_err = 0;
  rec_t pipe [2];   // in-flight instructions: [0] = one stage ahead, [1] = two
  int   tot = 0;    // unsaturated number of stall cycles since reset
  vec_t tbl [$];

  function automatic vec_t mk(bit hold, bit valid, logic [4:0] s1, bit u1,
                              logic [4:0] s2, bit u2, bit br, bit tk,
                              logic [4:0] dest, bit wb, bit mr,
                              bit [1:0] e_nf, bit [1:0] e_fw);
    vec_t v;
    v.hold = hold; v.valid = valid; v.s1 = s1; v.u1 = u1; v.s2 = s2; v.u2 = u2;
    v.br = br; v.tk = tk; v.dest = dest; v.wb = wb; v.mr = mr;
    v.e_nf = e_nf; v.e_fw = e_fw;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, N);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.hold         = v.hold;
    bus.id_valid     = v.valid;
    bus.id_src1      = v.s1;
    bus.id_src2      = v.s2;
    bus.id_src1_used = v.u1;
    bus.id_src2_used = v.u2;
    bus.id_branch    = v.br;
    bus.id_br_taken  = v.tk;
    bus.id_dest      = v.dest;
    bus.id_wb_en     = v.wb;
    bus.id_mem_r_en  = v.mr;
  endtask

  // Reference: does any used, non-zero source depend on an older in-flight write?
  function automatic bit model_hz(vec_t v);
    logic [4:0] srcs [2];
    bit         used [2];
    if (!v.valid) return 0;
    srcs[0] = v.s1; srcs[1] = v.s2;
    used[0] = v.u1; used[1] = v.u2;
    for (int k = 0; k < 2; k++) begin
      if (used[k] && srcs[k] != 0) begin
        for (int age = 0; age < 2; age++) begin
          if (pipe[age].v && pipe[age].wb && pipe[age].dest == srcs[k]) begin
`ifdef FORWARDING_EN
            if (age == 0 && (v.br || pipe[0].mr)) return 1;
            if (age == 1 && v.br && pipe[1].mr) return 1;
`else
            return 1;
`endif
          end
        end
      end
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) pipe[i] = '{default: 0};
    tot = 0;
  endtask

  // Called just after a rising edge: drive, check mid-cycle, then advance model.
  task automatic step(input vec_t v, input bit use_tbl);
    bit       hz, m_stall, m_flush;
    bit [1:0] e;
    drive(v);
    #4;
    hz      = model_hz(v);
    m_stall = hz && !v.hold;
    m_flush = v.valid && v.br && v.tk && !hz && !v.hold;
    check("stall", int'(bus.stall), int'(m_stall));
    check("bubble", int'(bus.bubble), int'(m_stall));
    check("flush", int'(bus.flush), int'(m_flush));
    check("stall_cnt", int'(bus.stall_cnt), (tot > 65535) ? 65535 : tot);
    check("sat_cnt", int'(sat_bus.stall_cnt), (tot > 15) ? 15 : tot);
    if (use_tbl) begin
`ifdef FORWARDING_EN
      e = v.e_fw;
`else
      e = v.e_nf;
`endif
      check("tbl_stall", int'(bus.stall), int'(e[1]));
      check("tbl_flush", int'(bus.flush), int'(e[0]));
    end
    @(posedge clk);
    #1;
    if (!v.hold) begin
      pipe[1] = pipe[0];
      if (m_stall || !v.valid) pipe[0] = '{default: 0};
      else pipe[0] = '{v: 1'b1, wb: v.wb, mr: v.mr, dest: v.dest};
      if (m_stall) tot++;
    end
  endtask

  initial begin
    vec_t v;

    // RAW on an ALU result: consumer repeated until it issues.
    tbl.push_back(mk(0, 1, 1, 0, 2, 0, 0, 0, 3, 1, 0, N, N));
    tbl.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 4, 1, 0, S, N));
    tbl.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 4, 1, 0, S, N));
    tbl.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 4, 1, 0, N, N));
    tbl.push_back(idle()); tbl.push_back(idle());
    // Load-use.
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 5, 1, 1, N, N));
    tbl.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0, 6, 1, 0, S, S));
    tbl.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0, 6, 1, 0, S, N));
    tbl.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0, 6, 1, 0, N, N));
    tbl.push_back(idle()); tbl.push_back(idle());
    // Taken branch, no hazard; then the same under hold.
    tbl.push_back(mk(0, 1, 7, 1, 8, 1, 1, 1, 0, 0, 0, F, F));
    tbl.push_back(mk(1, 1, 7, 1, 8, 1, 1, 1, 0, 0, 0, N, N));
    tbl.push_back(idle()); tbl.push_back(idle());
    // Taken branch on an EXE producer: flush waits for the stall to clear.
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 9, 1, 0, N, N));
    tbl.push_back(mk(0, 1, 9, 1, 0, 0, 1, 1, 0, 0, 0, S, S));
    tbl.push_back(mk(0, 1, 9, 1, 0, 0, 1, 1, 0, 0, 0, S, F));
    tbl.push_back(mk(0, 1, 9, 1, 0, 0, 1, 1, 0, 0, 0, F, F));
    tbl.push_back(idle()); tbl.push_back(idle());
    // r0 producer / r0 source, and an unused matching source.
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, N, N));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0, N, N));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 10, 1, 0, N, N));
    tbl.push_back(mk(0, 1, 0, 1, 10, 0, 0, 0, 2, 1, 0, N, N));
    tbl.push_back(idle()); tbl.push_back(idle());
    // hold for 3 cycles over a pending hazard, then the stall plays out.
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 11, 1, 0, N, N));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 11, 1, 0, 0, 0, 0, 12, 1, 0, N, N));
    tbl.push_back(mk(0, 1, 11, 1, 0, 0, 0, 0, 12, 1, 0, S, N));
    tbl.push_back(mk(0, 1, 11, 1, 0, 0, 0, 0, 12, 1, 0, S, N));
    tbl.push_back(mk(0, 1, 11, 1, 0, 0, 0, 0, 12, 1, 0, N, N));
    tbl.push_back(idle()); tbl.push_back(idle());

    drive(idle());
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state.
    step(idle(), 1'b0);

    // Asynchronous reset in the middle of a load-use stall.
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, 3, 1, 1, N, N), 1'b0);
    v = mk(0, 1, 3, 1, 0, 0, 0, 0, 4, 1, 0, N, N);
    drive(v);
    #2;
    check("pre_reset_stall", int'(bus.stall), 1);
    rst = 1'b0;
    #1;
    check("rst_stall", int'(bus.stall), 0);
    check("rst_bubble", int'(bus.bubble), 0);
    check("rst_flush", int'(bus.flush), 0);
    check("rst_cnt", int'(bus.stall_cnt), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    #1;
    check("post_reset_stall", int'(bus.stall), 0);
    step(v, 1'b0);
    step(idle(), 1'b0);
    step(idle(), 1'b0);

    foreach (tbl[i]) step(tbl[i], 1'b1);

    // Back-to-back self-dependent loads drive the narrow counter into saturation.
    for (int i = 0; i < 60; i++) step(mk(0, 1, 3, 1, 0, 0, 0, 0, 3, 1, 1, N, N), 1'b0);
    #4;
    check("sat_cnt_full", int'(sat_bus.stall_cnt), 15);
    @(posedge clk);
    #1;

    // Randomized traffic over a small register window to provoke collisions.
    for (int i = 0; i < 2000; i++) begin
      v = idle();
      v.hold  = ($urandom_range(0, 7) == 0);
      v.valid = ($urandom_range(0, 4) != 0);
      v.s1    = 5'($urandom_range(0, 3));
      v.s2    = 5'($urandom_range(0, 3));
      v.dest  = 5'($urandom_range(0, 3));
      v.u1    = 1'($urandom_range(0, 1));
      v.u2    = 1'($urandom_range(0, 1));
      v.br    = ($urandom_range(0, 3) == 0);
      v.tk    = 1'($urandom_range(0, 1));
      v.wb    = ($urandom_range(0, 3) != 0);
      v.mr    = 1'($urandom_range(0, 1));
      step(v, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
